ball_sequencer: RTL and testbench
=================================

# ball_sequencer

Per-frame controller for the ball. On each frame tick it erases the ball's old square, advances the ball one pixel diagonally with edge bounce, and redraws the square at the new position. Pixels go out one at a time through a valid/ready plot interface toward the VGA plotter. It sits between the frame-rate tick generator and the shared VGA write port, and owns the ball's position and direction registers.

## Interface
Parameters:
- X_MAX, 160, playfield width in pixels
- Y_MAX, 120, playfield height in pixels
- SIZE, 4, ball edge length in pixels (square)
- X_START, 78, reset x of ball top-left corner; must be ≤ X_MAX-SIZE
- Y_START, 58, reset y of ball top-left corner; must be ≤ Y_MAX-SIZE
- BALL_COLOUR, 3'b111, colour used when drawing
- BG_COLOUR, 3'b000, colour used when erasing

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse requesting one frame update
- enable  in  1  when low, new frame_ticks are ignored
- vga_ready  in  1  plotter accepts the pixel presented this cycle
- plot_en  out  1  pixel valid
- plot_x  out  10  pixel x
- plot_y  out  10  pixel y
- plot_colour  out  3  pixel colour
- ball_x  out  10  current ball top-left x
- ball_y  out  10  current ball top-left y
- x_dir  out  1  1 = moving +x, 0 = moving −x
- y_dir  out  1  1 = moving +y, 0 = moving −y
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  one-cycle pulse: tick dropped because one was already pending

## Operation
- Reset (async, resetn=0) gives:
  - state IDLE; ball_x=X_START, ball_y=Y_START; x_dir=1, y_dir=1
  - plot_en=0, plot_x=0, plot_y=0, plot_colour=BG_COLOUR
  - busy=0, overrun=0; pending=0, drawn=0, dx=dy=0
- Tick capture: frame_tick && enable sets pending.
  - If pending is already set and not being consumed this cycle, the tick is dropped and overrun pulses.
  - Only one tick can be pending.
- States:
  - IDLE: if pending, clear pending. Go to ERASE if drawn=1, else DRAW (first frame after reset skips erase).
  - ERASE: plot_colour=BG_COLOUR. Stream the SIZE×SIZE square at the old position. Go to MOVE after the last pixel is accepted.
  - MOVE: one cycle, plot_en=0. Go to DRAW.
  - DRAW: plot_colour=BALL_COLOUR. Stream the square at the new position. On the last accepted pixel, set drawn=1 and go to IDLE.
- Pixel streaming:
  - Order is row-major: dx counts 0..SIZE-1 fastest, then dy counts 0..SIZE-1.
  - plot_x=ball_x+dx, plot_y=ball_y+dy, 10-bit unsigned, no overflow given the parameter constraints.
  - plot_en is high throughout ERASE and DRAW.
- Handshake:
  - A pixel transfers on any edge where plot_en && vga_ready.
  - plot_x, plot_y and plot_colour hold steady while plot_en && !vga_ready.
  - dx/dy advance only on a transfer.
  - dx/dy are cleared on entry to ERASE and DRAW.
- Direction update in MOVE (decided from the pre-move position):
  - x: if ball_x == X_MAX-SIZE, x_dir←0; else if ball_x == 0, x_dir←1; else x_dir unchanged.
  - y: same rule using ball_y, Y_MAX-SIZE and y_dir.
  - ball_x←ball_x+1 if the new x_dir=1, else ball_x−1; same for y. Both axes update in the same cycle.
- Position stays within [0, X_MAX-SIZE] × [0, Y_MAX-SIZE] at all times.
- Corner hit (both axes at a limit): both directions flip in the same MOVE cycle.
- enable low mid-sequence: the current sequence completes. A tick already pending stays pending.
- Reset mid-sequence: everything returns to reset values immediately. plot_en drops asynchronously.

## Timing
- Tick at edge t while IDLE and pending=0: pending=1 after t. Leaves IDLE at edge t+1. plot_en=1 from cycle t+2.
- Tick arriving in the same cycle IDLE consumes a pending tick: it sets pending again, no overrun.
- With vga_ready tied high:
  - ERASE takes SIZE² cycles, MOVE 1, DRAW SIZE².
  - busy high for 2·SIZE²+1 cycles (33 for SIZE=4).
  - First frame after reset: busy for SIZE² cycles (DRAW only).
- Each vga_ready=0 cycle while plot_en=1 adds exactly one cycle.
- ball_x, ball_y, x_dir and y_dir change only on the MOVE→DRAW edge.
- overrun is registered: it asserts the cycle after the dropped tick.

## Test plan
- First frame after reset, ready=1, tick: 16 pixels (78..81, 58..61), colour 7, no erase, busy 16 cycles; ball stays (78,58).
- Second tick: 16 BG pixels at (78..81, 58..61), then 16 colour-7 pixels at (79..82, 59..62); ball_x=79, ball_y=59.
- X_START=156 (=X_MAX-SIZE), Y_START=0, drawn frame then tick: x_dir→0, y_dir→1; ball becomes (155,1).
- Corner: start (156,116), x_dir=y_dir=1: after MOVE, ball=(155,115), x_dir=0, y_dir=0.
- vga_ready toggles 1,0,1,0…: each pixel is held stable while ready=0; busy lasts 2·33−1 cycles for the full frame; pixel order unchanged.
- Two ticks during busy: the first sets pending, the second pulses overrun once; exactly one further frame runs. Reset asserted during DRAW: plot_en=0 and ball=(78,58) immediately.

Source files
------------

// File: rtl/ball_sequencer.sv
// ball_sequencer: per-frame ball controller. On each accepted frame tick it erases
// the old ball square, steps the ball one pixel diagonally (bouncing off the
// playfield edges) and redraws it, streaming pixels over a valid/ready interface.
module ball_sequencer #(
    parameter int unsigned X_MAX       = 160,
    parameter int unsigned Y_MAX       = 120,
    parameter int unsigned SIZE        = 4,
    parameter int unsigned X_START     = 78,
    parameter int unsigned Y_START     = 58,
    parameter logic [2:0]  BALL_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       vga_ready,
    output logic       plot_en,
    output logic [9:0] plot_x,
    output logic [9:0] plot_y,
    output logic [2:0] plot_colour,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       x_dir,
    output logic       y_dir,
    output logic       busy,
    output logic       overrun
);

    localparam logic [9:0] XLim   = 10'(X_MAX - SIZE);
    localparam logic [9:0] YLim   = 10'(Y_MAX - SIZE);
    localparam logic [9:0] LastD  = 10'(SIZE - 1);
    localparam logic [9:0] XStart = 10'(X_START);
    localparam logic [9:0] YStart = 10'(Y_START);

    typedef enum logic [1:0] {StIdle, StErase, StMove, StDraw} state_e;

    state_e     state_q, state_d;
    logic       pending_q, drawn_q, overrun_q;
    logic [9:0] dx_q, dy_q;
    logic [9:0] ball_x_q, ball_y_q;
    logic       x_dir_q, y_dir_q;

    logic       tick, consume, xfer, last_pix;
    logic       x_dir_n, y_dir_n;
    logic [9:0] ball_x_n, ball_y_n;

    assign tick     = frame_tick && enable;
    assign consume  = (state_q == StIdle) && pending_q;
    assign xfer     = plot_en && vga_ready;
    assign last_pix = (dx_q == LastD) && (dy_q == LastD);

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign x_dir   = x_dir_q;
    assign y_dir   = y_dir_q;
    assign overrun = overrun_q;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pending_q) state_d = drawn_q ? StErase : StDraw;
            StErase: if (xfer && last_pix) state_d = StMove;
            StMove:  state_d = StDraw;
            StDraw:  if (xfer && last_pix) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: pixel stream is zeroed whenever nothing is being plotted
    always_comb begin
        plot_en     = 1'b0;
        plot_x      = 10'd0;
        plot_y      = 10'd0;
        plot_colour = BG_COLOUR;
        busy        = (state_q != StIdle);
        if (state_q == StErase || state_q == StDraw) begin
            plot_en     = 1'b1;
            plot_x      = ball_x_q + dx_q;
            plot_y      = ball_y_q + dy_q;
            plot_colour = (state_q == StDraw) ? BALL_COLOUR : BG_COLOUR;
        end
    end

    // Bounce decision uses the pre-move position; a corner flips both axes at once
    always_comb begin
        x_dir_n = x_dir_q;
        y_dir_n = y_dir_q;
        if (ball_x_q == XLim)       x_dir_n = 1'b0;
        else if (ball_x_q == 10'd0) x_dir_n = 1'b1;
        if (ball_y_q == YLim)       y_dir_n = 1'b0;
        else if (ball_y_q == 10'd0) y_dir_n = 1'b1;
        ball_x_n = x_dir_n ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
        ball_y_n = y_dir_n ? ball_y_q + 10'd1 : ball_y_q - 10'd1;
    end

    // Tick capture: a single pending slot, overrun flags a tick lost to a full slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= tick | (pending_q & ~consume);
            overrun_q <= tick & pending_q & ~consume;
        end
    end

    // Pixel counters: cleared outside the streaming states, advance on transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx_q <= 10'd0;
            dy_q <= 10'd0;
        end else if (state_q == StIdle || state_q == StMove) begin
            dx_q <= 10'd0;
            dy_q <= 10'd0;
        end else if (xfer) begin
            if (dx_q == LastD) begin
                dx_q <= 10'd0;
                dy_q <= (dy_q == LastD) ? 10'd0 : dy_q + 10'd1;
            end else begin
                dx_q <= dx_q + 10'd1;
            end
        end
    end

    // Ball position/direction, plus the "something is on screen" flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x_q <= XStart;
            ball_y_q <= YStart;
            x_dir_q  <= 1'b1;
            y_dir_q  <= 1'b1;
            drawn_q  <= 1'b0;
        end else begin
            if (state_q == StMove) begin
                ball_x_q <= ball_x_n;
                ball_y_q <= ball_y_n;
                x_dir_q  <= x_dir_n;
                y_dir_q  <= y_dir_n;
            end
            if (state_q == StDraw && xfer && last_pix) drawn_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ball_sequencer.sv
// Directed bench for ball_sequencer: three instances share stimulus and differ
// only in start position (centre, right/top edge, bottom-right corner).
module tb_ball_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic frame_tick = 1'b0;
    logic enable = 1'b1;
    logic vga_ready = 1'b1;

    logic       a_en, a_busy, a_ovr, a_xd, a_yd;
    logic [9:0] a_x, a_y, a_bx, a_by;
    logic [2:0] a_col;
    logic       b_en, b_busy, b_ovr, b_xd, b_yd;
    logic [9:0] b_x, b_y, b_bx, b_by;
    logic [2:0] b_col;
    logic       c_en, c_busy, c_ovr, c_xd, c_yd;
    logic [9:0] c_x, c_y, c_bx, c_by;
    logic [2:0] c_col;

    ball_sequencer u_a (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
        .vga_ready(vga_ready), .plot_en(a_en), .plot_x(a_x), .plot_y(a_y),
        .plot_colour(a_col), .ball_x(a_bx), .ball_y(a_by), .x_dir(a_xd), .y_dir(a_yd),
        .busy(a_busy), .overrun(a_ovr)
    );

    ball_sequencer #(.X_START(156), .Y_START(0)) u_b (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
        .vga_ready(vga_ready), .plot_en(b_en), .plot_x(b_x), .plot_y(b_y),
        .plot_colour(b_col), .ball_x(b_bx), .ball_y(b_by), .x_dir(b_xd), .y_dir(b_yd),
        .busy(b_busy), .overrun(b_ovr)
    );

    ball_sequencer #(.X_START(156), .Y_START(116)) u_c (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
        .vga_ready(vga_ready), .plot_en(c_en), .plot_x(c_x), .plot_y(c_y),
        .plot_colour(c_col), .ball_x(c_bx), .ball_y(c_by), .x_dir(c_xd), .y_dir(c_yd),
        .busy(c_busy), .overrun(c_ovr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    int          busy_cycles;
    bit          toggle_mode = 1'b0;

    // Expected pixel list: optional erase at (ox,oy) then draw at (nx,ny), row-major
    task automatic build_exp(input bit erase, input int ox, input int oy,
                             input int nx, input int ny);
        exp_q.delete();
        if (erase)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    exp_q.push_back({3'b000, 10'(ox + c), 10'(oy + r)});
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back({3'b111, 10'(nx + c), 10'(ny + r)});
    endtask

    // Pulse a tick, then stream one frame of instance A, recording transfers.
    // In toggle mode each plotted pixel sees ready=0 then ready=1.
    task automatic run_frame();
        bit          seen = 1'b0;
        bit          phase = 1'b0;
        bit          stalled = 1'b0;
        logic [22:0] prev = '0;
        got_q.delete();
        busy_cycles = 0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (a_busy) begin
                seen = 1'b1;
                busy_cycles++;
            end else if (seen) begin
                break;
            end
            if (a_en && stalled) check("hold_stable", {a_col, a_x, a_y}, prev);
            if (toggle_mode && a_en) begin
                vga_ready = phase;
                phase = ~phase;
            end else begin
                vga_ready = 1'b1;
            end
            stalled = a_en && !vga_ready;
            prev = {a_col, a_x, a_y};
            if (a_en && vga_ready) got_q.push_back({a_col, a_x, a_y});
            @(negedge clk);
        end
        check("frame_started", 32'(seen), 1);
        check("frame_ended", 32'(a_busy), 0);
        vga_ready = 1'b1;
    endtask

    task automatic compare_pixels(input string tag);
        int n;
        check({tag, "_npix"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    int rises, ovrs;
    bit prev_busy;

    initial begin
        // Reset state
        #12;
        check("rst_plot_en", 32'(a_en), 0);
        check("rst_plot_x", 32'(a_x), 0);
        check("rst_plot_y", 32'(a_y), 0);
        check("rst_colour", 32'(a_col), 0);
        check("rst_ball_x", 32'(a_bx), 78);
        check("rst_ball_y", 32'(a_by), 58);
        check("rst_dirs", {30'd0, a_xd, a_yd}, 3);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_overrun", 32'(a_ovr), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // First frame: draw only
        run_frame();
        build_exp(1'b0, 0, 0, 78, 58);
        compare_pixels("f1");
        check("f1_busy", busy_cycles, 16);
        check("f1_ball", {6'd0, a_bx, 6'd0, a_by}, {6'd0, 10'd78, 6'd0, 10'd58});

        // Second frame: erase + move + draw
        run_frame();
        build_exp(1'b1, 78, 58, 79, 59);
        compare_pixels("f2");
        check("f2_busy", busy_cycles, 33);
        check("f2_ball", {6'd0, a_bx, 6'd0, a_by}, {6'd0, 10'd79, 6'd0, 10'd59});
        check("f2_dirs", {30'd0, a_xd, a_yd}, 3);
        check("edge_ball", {6'd0, b_bx, 6'd0, b_by}, {6'd0, 10'd155, 6'd0, 10'd1});
        check("edge_dirs", {30'd0, b_xd, b_yd}, 1);
        check("corner_ball", {6'd0, c_bx, 6'd0, c_by}, {6'd0, 10'd155, 6'd0, 10'd115});
        check("corner_dirs", {30'd0, c_xd, c_yd}, 0);

        // Back-pressure: every pixel stalled once
        toggle_mode = 1'b1;
        run_frame();
        toggle_mode = 1'b0;
        build_exp(1'b1, 79, 59, 80, 60);
        compare_pixels("f3");
        check("f3_busy", busy_cycles, 65);
        check("f3_ball", {6'd0, a_bx, 6'd0, a_by}, {6'd0, 10'd80, 6'd0, 10'd60});

        // Ticks ignored while disabled
        enable = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_busy) rises++;
            @(negedge clk);
        end
        check("disabled_busy", rises, 0);
        enable = 1'b1;

        // Overrun: tick starts a frame, one more pends, a third is dropped
        rises = 0;
        ovrs = 0;
        prev_busy = 1'b0;
        frame_tick = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_busy && !prev_busy) rises++;
            if (a_ovr) ovrs++;
            if (i == 6) check("ovr_pulse_time", 32'(a_ovr), 1);
            prev_busy = a_busy;
            frame_tick = (i == 3 || i == 5);
        end
        check("ovr_frames", rises, 2);
        check("ovr_count", ovrs, 1);
        check("ovr_ball", {6'd0, a_bx, 6'd0, a_by}, {6'd0, 10'd82, 6'd0, 10'd62});

        // Reset during DRAW
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (a_en && a_col == 3'b111) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("draw_reached", 32'(hit), 1);
        end
        resetn = 1'b0;
        #1;
        check("mid_rst_plot_en", 32'(a_en), 0);
        check("mid_rst_ball", {6'd0, a_bx, 6'd0, a_by}, {6'd0, 10'd78, 6'd0, 10'd58});
        check("mid_rst_busy", 32'(a_busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
